// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main controller.
// The optional JUMP path is enabled with MULTICYCLE_CONTROL_JUMP_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    JUMP      = 4'd12,
    TRAP      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // An instruction retires when control returns to FETCH from any state other
  // than FETCH itself (stall) or IDLE (start-up).
  function automatic logic retire_edge(input state_e cur, input state_e nxt);
    logic r;
    r = 1'b0;
    if ((nxt == FETCH) && (cur != FETCH) && (cur != IDLE)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore decode of controller state into datapath selects and enables.
// JUMP outputs exist only when MULTICYCLE_CONTROL_JUMP_EN is defined.
module mc_out_decode
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       trap_o
);

  state_e state_s;
  assign state_s = state_e'(state_i);

  // Control outputs per state; only FETCH looks at mem_ready.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRC_B_REG;
    alu_op_o        = ALU_ADD;
    pc_source_o     = PC_SRC_ALU;
    trap_o          = 1'b0;
    case (state_s)
      IDLE: begin
        mem_read_o = 1'b0;
      end
      FETCH: begin
        mem_read_o  = 1'b1;
        i_or_d_o    = 1'b0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = SRC_B_FOUR;
        alu_op_o    = ALU_ADD;
        pc_source_o = PC_SRC_ALU;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE: begin
        alu_src_a_o = 1'b0;
        alu_src_b_o = SRC_B_IMM_SH2;
        alu_op_o    = ALU_ADD;
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_ADD;
      end
      MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      MEM_WB: begin
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_REG;
        alu_op_o    = ALU_FUNCT;
      end
      ALU_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_src_b_o     = SRC_B_REG;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PC_SRC_ALUOUT;
      end
      ADDI_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_ADD;
      end
      ADDI_WB: begin
        reg_dst_o   = 1'b0;
        reg_write_o = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PC_SRC_JUMP;
      end
`endif
      TRAP: begin
        trap_o = 1'b1;
      end
      default: begin
        trap_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: state register, next-state logic and
// retired-instruction counter. Define MULTICYCLE_CONTROL_JUMP_EN to support j.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   retired_q;
  logic [CNT_W-1:0]   retired_d;
  logic               retire_s;

  // Next-state sequencing; undefined encodings fall into TRAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_W'(OP_LW), OP_W'(OP_SW): state_d = MEM_ADDR;
          OP_W'(OP_RTYPE):            state_d = EXECUTE;
          OP_W'(OP_BEQ):              state_d = BRANCH;
          OP_W'(OP_ADDI):             state_d = ADDI_EXEC;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OP_W'(OP_J):                state_d = JUMP;
`endif
          default:                    state_d = TRAP;
        endcase
      end
      MEM_ADDR: begin
        if (opcode == OP_W'(OP_LW)) begin
          state_d = MEM_READ;
        end else begin
          state_d = MEM_WRITE;
        end
      end
      MEM_READ: begin
        if (mem_ready) begin
          state_d = MEM_WB;
        end else begin
          state_d = MEM_READ;
        end
      end
      MEM_WRITE: begin
        if (mem_ready) begin
          state_d = FETCH;
        end else begin
          state_d = MEM_WRITE;
        end
      end
      EXECUTE:   state_d = ALU_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      MEM_WB, ALU_WB, BRANCH, ADDI_WB: begin
        state_d = FETCH;
      end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      JUMP:      state_d = FETCH;
`endif
      TRAP:      state_d = TRAP;
      default:   state_d = TRAP;
    endcase
  end

  // Retire counter advances on every completing return to FETCH.
  always_comb begin
    retire_s = retire_edge(state_q, state_d);
    if (retire_s) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

  mc_out_decode u_out_decode (
    .state_i         (state_q),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .i_or_d_o        (i_or_d),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .pc_source_o     (pc_source),
    .trap_o          (trap)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected control
// sequences built from the instruction set rules, with random memory wait states.
module tb_multicycle_control;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = 6'd0;
  logic             mem_ready = 1'b0;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a, trap;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(.OP_W(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .trap(trap), .retired(retired)
  );

  typedef enum int {P_FETCH, P_DECODE, P_MADDR, P_MREAD, P_MWB, P_MWRITE, P_EXEC,
                    P_AWB, P_BR, P_AEXEC, P_IWB, P_JUMP, P_TRAP} phase_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctrl_t;

  typedef struct {
    phase_e ph;
    logic   mr;
  } step_t;

  ctrl_t            obs_s;
  step_t            seq_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  assign obs_s = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, trap};

  // Expected control word for each instruction phase.
  function automatic ctrl_t exp_ctrl(input phase_e ph, input logic mr);
    ctrl_t c;
    c = '0;
    case (ph)
      P_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      P_DECODE: c.alu_src_b = 2'b11;
      P_MADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      P_MREAD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      P_MWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      P_MWRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      P_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      P_AWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      P_BR:     begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      P_AEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      P_IWB:    c.reg_write = 1'b1;
      P_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      P_TRAP:   c.trap = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Build the cycle-by-cycle phase list of one instruction with the given waits.
  task automatic build(input logic [5:0] op, input int fw, input int mw, output bit retires);
    seq_q.delete();
    retires = 1'b1;
    repeat (fw) seq_q.push_back('{P_FETCH, 1'b0});
    seq_q.push_back('{P_FETCH, 1'b1});
    seq_q.push_back('{P_DECODE, rnd_bit()});
    case (op)
      6'd35: begin
        seq_q.push_back('{P_MADDR, rnd_bit()});
        repeat (mw) seq_q.push_back('{P_MREAD, 1'b0});
        seq_q.push_back('{P_MREAD, 1'b1});
        seq_q.push_back('{P_MWB, rnd_bit()});
      end
      6'd43: begin
        seq_q.push_back('{P_MADDR, rnd_bit()});
        repeat (mw) seq_q.push_back('{P_MWRITE, 1'b0});
        seq_q.push_back('{P_MWRITE, 1'b1});
      end
      6'd0: begin
        seq_q.push_back('{P_EXEC, rnd_bit()});
        seq_q.push_back('{P_AWB, rnd_bit()});
      end
      6'd4: seq_q.push_back('{P_BR, rnd_bit()});
      6'd8: begin
        seq_q.push_back('{P_AEXEC, rnd_bit()});
        seq_q.push_back('{P_IWB, rnd_bit()});
      end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      6'd2: seq_q.push_back('{P_JUMP, rnd_bit()});
`endif
      default: begin
        seq_q.push_back('{P_TRAP, rnd_bit()});
        retires = 1'b0;
      end
    endcase
  endtask

  task automatic step(input logic mr, input logic [5:0] op, output ctrl_t c, output logic [CNT_W-1:0] r);
    mem_ready = mr;
    opcode = op;
    @(negedge clk);
    c = obs_s;
    r = retired;
    @(posedge clk);
    #1;
  endtask

  // Run one instruction, comparing every cycle's controls and the retire count.
  task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw);
    bit ret_f;
    ctrl_t c, e;
    logic [CNT_W-1:0] r;
    build(op, fw, mw, ret_f);
    foreach (seq_q[i]) begin
      step(seq_q[i].mr, (seq_q[i].ph == P_FETCH) ? 6'($urandom) : op, c, r);
      e = exp_ctrl(seq_q[i].ph, seq_q[i].mr);
      checks++;
      if (c !== e) begin
        errors++;
        $display("FAIL %s ctrl cycle %0d: got %h expected %h", name, i, c, e);
      end
      checks++;
      if (r !== exp_ret) begin
        errors++;
        $display("FAIL %s retired cycle %0d: got %0d expected %0d", name, i, r, exp_ret);
      end
    end
    if (ret_f) exp_ret = exp_ret + 1;
  endtask

  task automatic apply_reset();
    ctrl_t c;
    logic [CNT_W-1:0] r;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = '0;
    step(1'b1, 6'd0, c, r);
    checks++;
    if (c !== '0 || r !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got ctrl %h retired %0d expected 0 and 0", c, r);
    end
  endtask

  task automatic test_reset();
    ctrl_t c;
    logic [CNT_W-1:0] r;
    #3;
    checks++;
    if (obs_s !== '0 || retired !== '0) begin
      errors++;
      $display("FAIL reset_state: got ctrl %h retired %0d expected 0 and 0", obs_s, retired);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 6'd0, c, r);
    checks++;
    if (c !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0", c);
    end
    step(1'b0, 6'd0, c, r);
    checks++;
    if (c !== exp_ctrl(P_FETCH, 1'b0)) begin
      errors++;
      $display("FAIL reset_first_fetch: got %h expected %h", c, exp_ctrl(P_FETCH, 1'b0));
    end
  endtask

  task automatic test_lw();
    run_instr("lw", 6'd35, 0, 0);
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL lw_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_stalls();
    run_instr("fetch_stall", 6'd0, 3, 0);
    run_instr("sw_stall", 6'd43, 0, 2);
    run_instr("lw_stall", 6'd35, 1, 3);
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] base;
    base = exp_ret;
    run_instr("mix_rtype", 6'd0, 0, 0);
    run_instr("mix_beq", 6'd4, 0, 0);
    run_instr("mix_addi", 6'd8, 0, 0);
    checks++;
    if (retired !== base + 3) begin
      errors++;
      $display("FAIL mix_retired: got %0d expected %0d", retired, base + 3);
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 40; n++) begin
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      case ($urandom_range(0, 5))
`else
      case ($urandom_range(0, 4))
`endif
        0: op = 6'd0;
        1: op = 6'd4;
        2: op = 6'd8;
        3: op = 6'd35;
        4: op = 6'd43;
        default: op = 6'd2;
      endcase
      run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_read();
    ctrl_t c;
    logic [CNT_W-1:0] r;
    step(1'b1, 6'd35, c, r);
    step(1'b0, 6'd35, c, r);
    step(1'b0, 6'd35, c, r);
    step(1'b0, 6'd35, c, r);
    checks++;
    if (mem_read !== 1'b1 || i_or_d !== 1'b1 || retired === '0) begin
      errors++;
      $display("FAIL pre_reset_mem_read: got mem_read %b i_or_d %b retired %0d", mem_read, i_or_d, retired);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_s !== '0 || retired !== '0) begin
      errors++;
      $display("FAIL mid_read_reset: got ctrl %h retired %0d expected 0 and 0", obs_s, retired);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = '0;
    step(1'b1, 6'd35, c, r);
    checks++;
    if (c !== '0 || r !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got ctrl %h retired %0d expected 0 and 0", c, r);
    end
    step(1'b0, 6'd35, c, r);
    checks++;
    if (c !== exp_ctrl(P_FETCH, 1'b0)) begin
      errors++;
      $display("FAIL post_reset_fetch: got %h expected %h", c, exp_ctrl(P_FETCH, 1'b0));
    end
  endtask

  task automatic test_opcode2();
    logic [CNT_W-1:0] base;
    base = exp_ret;
    run_instr("opcode2", 6'd2, 0, 0);
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    checks++;
    if (retired !== base + 1) begin
      errors++;
      $display("FAIL jump_retired: got %0d expected %0d", retired, base + 1);
    end
`else
    checks++;
    if (trap !== 1'b1 || retired !== base) begin
      errors++;
      $display("FAIL opcode2_trap: got trap %b retired %0d expected 1 and %0d", trap, retired, base);
    end
    apply_reset();
`endif
  endtask

  task automatic test_trap();
    ctrl_t c;
    logic [CNT_W-1:0] r;
    run_instr("illegal", 6'd63, 0, 0);
    for (int k = 1; k < 100; k++) begin
      step(rnd_bit(), 6'($urandom), c, r);
      checks++;
      if (c !== exp_ctrl(P_TRAP, 1'b0) || r !== exp_ret) begin
        errors++;
        $display("FAIL trap_hold cycle %0d: got ctrl %h retired %0d expected %h and %0d",
                 k, c, r, exp_ctrl(P_TRAP, 1'b0), exp_ret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_stalls();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    test_opcode2();
    test_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
